// File: rtl/sw_job_sequencer.sv
// Job sequencer between the RX/TX byte streams and SW_core: collects a length+sequence
// frame, issues it to the core, and streams the 6-byte score/column/row result back.
module sw_job_sequencer #(
  parameter int SEQ_MAX = 128,
  parameter int SCORE_W = 10,
  parameter int COORD_W = 8,
  parameter int LEN_W   = 8
) (
  input  logic                 avm_clk,
  input  logic                 avm_rst_n,
  input  logic                 i_rx_valid,
  input  logic [7:0]           i_rx_data,
  output logic                 o_rx_ready,
  output logic                 o_tx_valid,
  output logic [7:0]           o_tx_data,
  input  logic                 i_tx_ready,
  input  logic                 i_core_ready,
  output logic                 o_core_valid,
  output logic [2*SEQ_MAX-1:0] o_seq_ref,
  output logic [2*SEQ_MAX-1:0] o_seq_read,
  output logic [LEN_W-1:0]     o_ref_len,
  output logic [LEN_W-1:0]     o_read_len,
  output logic                 o_core_ready,
  input  logic                 i_core_valid,
  input  logic [SCORE_W-1:0]   i_core_score,
  input  logic [COORD_W-1:0]   i_core_column,
  input  logic [COORD_W-1:0]   i_core_row,
  output logic                 o_busy,
  output logic                 o_len_err,
  output logic [15:0]          o_job_count
);
  localparam int SEQ_W  = 2 * SEQ_MAX;
  localparam int NBYTES = SEQ_W / 8;
  localparam int CNT_W  = ($clog2(NBYTES) > 3) ? $clog2(NBYTES) : 3;
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(SEQ_MAX);

  typedef enum logic [2:0] {
    S_LEN_REF, S_LEN_READ, S_LOAD_REF, S_LOAD_READ, S_ISSUE, S_WAIT, S_SEND
  } state_t;

  typedef struct packed {
    logic [SCORE_W-1:0] score;
    logic [COORD_W-1:0] column;
    logic [COORD_W-1:0] row;
  } result_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  result_t            res;
  logic               rx_fire, tx_fire, last_byte, last_tx;
  logic [LEN_W-1:0]   len_in, len_clamped;
  logic               len_bad;
  logic [15:0]        score16, column16, row16;

  assign rx_fire   = i_rx_valid && o_rx_ready;
  assign tx_fire   = o_tx_valid && i_tx_ready;
  assign last_byte = (cnt == CNT_W'(NBYTES - 1));
  assign last_tx   = (cnt == CNT_W'(5));
  assign o_busy    = (state != S_LEN_REF);

  // Out-of-range lengths are replaced by the maximum so the core never sees a bogus length.
  assign len_in      = LEN_W'(i_rx_data);
  assign len_bad     = (len_in == '0) || (len_in > MAX_LEN);
  assign len_clamped = len_bad ? MAX_LEN : len_in;

  assign score16  = 16'(res.score);
  assign column16 = 16'(res.column);
  assign row16    = 16'(res.row);

  always_ff @(posedge avm_clk) begin
    if (!avm_rst_n) state <= S_LEN_REF;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    o_rx_ready   = 1'b0;
    o_core_valid = 1'b0;
    o_core_ready = 1'b0;
    o_tx_valid   = 1'b0;
    o_tx_data    = 8'h00;
    case (state)
      S_LEN_REF: begin
        o_rx_ready = 1'b1;
        if (rx_fire) state_nxt = S_LEN_READ;
      end
      S_LEN_READ: begin
        o_rx_ready = 1'b1;
        if (rx_fire) state_nxt = S_LOAD_REF;
      end
      S_LOAD_REF: begin
        o_rx_ready = 1'b1;
        if (rx_fire && last_byte) state_nxt = S_LOAD_READ;
      end
      S_LOAD_READ: begin
        o_rx_ready = 1'b1;
        if (rx_fire && last_byte) state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        o_core_valid = 1'b1;
        if (i_core_ready) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        o_core_ready = 1'b1;
        if (i_core_valid) state_nxt = S_SEND;
      end
      S_SEND: begin
        o_tx_valid = 1'b1;
        case (cnt[2:0])
          3'd0:    o_tx_data = score16[15:8];
          3'd1:    o_tx_data = score16[7:0];
          3'd2:    o_tx_data = column16[15:8];
          3'd3:    o_tx_data = column16[7:0];
          3'd4:    o_tx_data = row16[15:8];
          3'd5:    o_tx_data = row16[7:0];
          default: o_tx_data = 8'h00;
        endcase
        if (tx_fire && last_tx) state_nxt = S_LEN_REF;
      end
      default: state_nxt = S_LEN_REF;
    endcase
  end

  always_ff @(posedge avm_clk) begin
    if (!avm_rst_n) begin
      cnt         <= '0;
      res         <= '0;
      o_seq_ref   <= '0;
      o_seq_read  <= '0;
      o_ref_len   <= MAX_LEN;
      o_read_len  <= MAX_LEN;
      o_len_err   <= 1'b0;
      o_job_count <= '0;
    end else begin
      case (state)
        S_LEN_REF: if (rx_fire) begin
          o_ref_len <= len_clamped;
          if (len_bad) o_len_err <= 1'b1;
        end
        S_LEN_READ: if (rx_fire) begin
          o_read_len <= len_clamped;
          if (len_bad) o_len_err <= 1'b1;
          cnt <= '0;
        end
        S_LOAD_REF: if (rx_fire) begin
          o_seq_ref <= {o_seq_ref[SEQ_W-9:0], i_rx_data};
          cnt       <= last_byte ? '0 : cnt + 1'b1;
        end
        S_LOAD_READ: if (rx_fire) begin
          o_seq_read <= {o_seq_read[SEQ_W-9:0], i_rx_data};
          cnt        <= last_byte ? '0 : cnt + 1'b1;
        end
        S_WAIT: if (i_core_valid) begin
          res <= '{score: i_core_score, column: i_core_column, row: i_core_row};
          cnt <= '0;
        end
        S_SEND: if (tx_fire) begin
          if (last_tx) begin
            cnt         <= '0;
            o_job_count <= o_job_count + 16'd1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
